// File: rtl/ecc_op_controller.sv
// ecc_op_controller: sequences the ECC encode / noise / decode datapath.
// A CTRL write in IDLE launches one operation; the controller pulses the
// datapath start strobes, steers the decoder source mux, guards every run
// state with a timeout and keeps a sticky status word for APB readback.
module ecc_op_controller #(
    parameter int AMBA_WORD      = 32,
    parameter int TMO_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_wr,
    input  logic [1:0]           ctrl_op,
    input  logic [1:0]           cw_width,
    input  logic                 enc_done,
    input  logic                 dec_done,
    output logic                 enc_start,
    output logic                 dec_start,
    output logic                 dec_src_sel,
    output logic                 noise_en,
    output logic [1:0]           width_lat,
    output logic                 busy,
    output logic                 op_done,
    output logic [AMBA_WORD-1:0] status
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENC_RUN = 3'd1,
        NOISE   = 3'd2,
        DEC_RUN = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] OP_ENC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_FULL = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;
    localparam logic [1:0] WID_ILL = 2'b11;
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [TMO_WIDTH-1:0]   cnt_r;
    logic [TMO_WIDTH-1:0]   cnt_nxt_s;
    logic [1:0]             op_r;
    logic [1:0]             op_nxt_s;
    logic                   accept_s;
    logic                   illegal_s;
    logic                   ignored_s;
    logic                   tmo_s;

    logic                   enc_start_nxt_s;
    logic                   dec_start_nxt_s;
    logic                   dec_src_sel_nxt_s;
    logic                   noise_en_nxt_s;
    logic [1:0]             width_lat_nxt_s;
    logic                   busy_nxt_s;
    logic                   op_done_nxt_s;
    logic [AMBA_WORD-1:0]   status_nxt_s;

    // State, counter and registered outputs; rst clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {TMO_WIDTH{1'b0}};
            op_r        <= 2'b00;
            enc_start   <= 1'b0;
            dec_start   <= 1'b0;
            dec_src_sel <= 1'b0;
            noise_en    <= 1'b0;
            width_lat   <= 2'b00;
            busy        <= 1'b0;
            op_done     <= 1'b0;
            status      <= {AMBA_WORD{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            op_r        <= op_nxt_s;
            enc_start   <= enc_start_nxt_s;
            dec_start   <= dec_start_nxt_s;
            dec_src_sel <= dec_src_sel_nxt_s;
            noise_en    <= noise_en_nxt_s;
            width_lat   <= width_lat_nxt_s;
            busy        <= busy_nxt_s;
            op_done     <= op_done_nxt_s;
            status      <= status_nxt_s;
        end
    end

    // Next-state logic: command decode, done handshakes and timeout.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        illegal_s   = 1'b0;
        tmo_s       = 1'b0;
        ignored_s   = ctrl_wr && (state_r != IDLE);
        case (state_r)
            IDLE: begin
                if (ctrl_wr && ((ctrl_op == OP_ILL) || (cw_width == WID_ILL))) begin
                    illegal_s = 1'b1;
                end else if (ctrl_wr) begin
                    accept_s    = 1'b1;
                    state_nxt_s = (ctrl_op == OP_DEC) ? DEC_RUN : ENC_RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ENC_RUN: begin
                // A done arriving on the last counted cycle beats the timeout.
                if (enc_done) begin
                    state_nxt_s = (op_r == OP_FULL) ? NOISE : DONE;
                end else if (cnt_r == TMO_LAST) begin
                    state_nxt_s = DONE;
                    tmo_s       = 1'b1;
                end else begin
                    state_nxt_s = ENC_RUN;
                end
            end
            NOISE: begin
                state_nxt_s = DEC_RUN;
            end
            DEC_RUN: begin
                if (dec_done) begin
                    state_nxt_s = DONE;
                end else if (cnt_r == TMO_LAST) begin
                    state_nxt_s = DONE;
                    tmo_s       = 1'b1;
                end else begin
                    state_nxt_s = DEC_RUN;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output next values derived from the upcoming state so that every
    // output is a flop and the start strobes line up with state entry.
    always_comb begin
        op_nxt_s        = accept_s ? ctrl_op : op_r;
        width_lat_nxt_s = accept_s ? cw_width : width_lat;
        enc_start_nxt_s = (state_nxt_s == ENC_RUN) && (state_r != ENC_RUN);
        dec_start_nxt_s = (state_nxt_s == DEC_RUN) && (state_r != DEC_RUN);
        noise_en_nxt_s  = (state_nxt_s == NOISE);
        busy_nxt_s      = (state_nxt_s == ENC_RUN) || (state_nxt_s == NOISE) ||
                          (state_nxt_s == DEC_RUN);
        op_done_nxt_s   = (state_nxt_s == DONE);

        // Counter restarts on every state change, counts while running.
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = {TMO_WIDTH{1'b0}};
        end else if ((state_r == ENC_RUN) || (state_r == DEC_RUN)) begin
            cnt_nxt_s = cnt_r + {{(TMO_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end

        // Decoder reads the noisy codeword from NOISE until back in IDLE.
        case (state_nxt_s)
            NOISE:   dec_src_sel_nxt_s = 1'b1;
            DEC_RUN: dec_src_sel_nxt_s = (state_r == NOISE) ? 1'b1 :
                                         ((state_r == DEC_RUN) ? dec_src_sel : 1'b0);
            DONE:    dec_src_sel_nxt_s = dec_src_sel;
            default: dec_src_sel_nxt_s = 1'b0;
        endcase

        status_nxt_s       = status;
        status_nxt_s[0]    = busy_nxt_s;
        status_nxt_s[1]    = op_done_nxt_s ? 1'b1 : (accept_s ? 1'b0 : status[1]);
        status_nxt_s[2]    = tmo_s ? 1'b1 : (accept_s ? 1'b0 : status[2]);
        status_nxt_s[3]    = illegal_s ? 1'b1 : (accept_s ? 1'b0 : status[3]);
        status_nxt_s[5:4]  = op_nxt_s;
        status_nxt_s[7:6]  = width_lat_nxt_s;
        status_nxt_s[8]    = ignored_s ? 1'b1 : (accept_s ? 1'b0 : status[8]);
    end

endmodule

// File: tb/tb_ecc_op_controller.sv
// Directed bench for ecc_op_controller: table of operations with
// hand-computed cycle positions and status words, plus reset, illegal
// command and mid-operation reset sequences.
module tb_ecc_op_controller;

    localparam int NEVER = 100000;

    logic        clk;
    logic        rst;
    logic        ctrl_wr;
    logic [1:0]  ctrl_op;
    logic [1:0]  cw_width;
    logic        enc_done;
    logic        dec_done;
    logic        enc_start;
    logic        dec_start;
    logic        dec_src_sel;
    logic        noise_en;
    logic [1:0]  width_lat;
    logic        busy;
    logic        op_done;
    logic [31:0] status;

    int n_checks;
    int n_errors;

    ecc_op_controller #(
        .AMBA_WORD(32), .TMO_WIDTH(8), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk), .rst(rst), .ctrl_wr(ctrl_wr), .ctrl_op(ctrl_op),
        .cw_width(cw_width), .enc_done(enc_done), .dec_done(dec_done),
        .enc_start(enc_start), .dec_start(dec_start),
        .dec_src_sel(dec_src_sel), .noise_en(noise_en),
        .width_lat(width_lat), .busy(busy), .op_done(op_done),
        .status(status)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle indices count from 1 = first cycle after the accepting edge;
    // 0 means the event must not occur.
    typedef struct {
        logic [1:0]  op;
        logic [1:0]  width;
        int          enc_lat;
        int          dec_lat;
        int          ovr;
        int          exp_enc;
        int          exp_noise;
        int          exp_dec;
        int          exp_done;
        int          exp_busy;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int enc_n, enc_k, noi_n, noi_k, dec_n, dec_k, done_n, done_k;
        int busy_n, sel_bad, st0_bad, dec_go;
        logic [31:0] fin_status;
        logic [1:0]  fin_width;
        string pfx;
        enc_n = 0; enc_k = 0; noi_n = 0; noi_k = 0; dec_n = 0; dec_k = 0;
        done_n = 0; done_k = 0; busy_n = 0; sel_bad = 0; st0_bad = 0;
        fin_status = 32'h0; fin_width = 2'b00;
        dec_go = (v.op == 2'b01) ? (1 + v.dec_lat) : (v.enc_lat + 3 + v.dec_lat);
        pfx = $sformatf("v%0d", idx);
        @(negedge clk);
        ctrl_wr = 1'b1; ctrl_op = v.op; cw_width = v.width;
        for (int k = 1; k <= v.exp_done + 1; k++) begin
            @(negedge clk);
            if (enc_start) begin enc_n++; if (enc_k == 0) enc_k = k; end
            if (noise_en)  begin noi_n++; if (noi_k == 0) noi_k = k; end
            if (dec_start) begin dec_n++; if (dec_k == 0) dec_k = k; end
            if (op_done)   begin done_n++; if (done_k == 0) done_k = k; end
            if (busy) busy_n++;
            if (status[0] !== busy) st0_bad++;
            if (dec_src_sel !== ((v.exp_noise != 0) && (k >= v.exp_noise) && (k <= v.exp_done)))
                sel_bad++;
            fin_status = status;
            fin_width  = width_lat;
            ctrl_wr  = (k == v.ovr);
            ctrl_op  = 2'b01;
            cw_width = 2'b10;
            enc_done = (k == 1 + v.enc_lat);
            dec_done = (k == dec_go);
        end
        ctrl_wr = 1'b0; enc_done = 1'b0; dec_done = 1'b0;
        chk({pfx, " enc_start count"}, enc_n, (v.exp_enc != 0) ? 1 : 0);
        chk({pfx, " enc_start cycle"}, enc_k, v.exp_enc);
        chk({pfx, " noise_en count"}, noi_n, (v.exp_noise != 0) ? 1 : 0);
        chk({pfx, " noise_en cycle"}, noi_k, v.exp_noise);
        chk({pfx, " dec_start count"}, dec_n, (v.exp_dec != 0) ? 1 : 0);
        chk({pfx, " dec_start cycle"}, dec_k, v.exp_dec);
        chk({pfx, " op_done count"}, done_n, 1);
        chk({pfx, " op_done cycle"}, done_k, v.exp_done);
        chk({pfx, " busy cycles"}, busy_n, v.exp_busy);
        chk({pfx, " dec_src_sel bad cycles"}, sel_bad, 0);
        chk({pfx, " status0 vs busy bad cycles"}, st0_bad, 0);
        chk({pfx, " final status"}, fin_status, v.exp_status);
        chk({pfx, " width_lat"}, {30'h0, fin_width}, {30'h0, v.exp_status[7:6]});
    endtask

    // Sample outputs idle for a few cycles after an illegal command.
    task automatic run_illegal(input string name, input logic [1:0] op, input logic [1:0] w);
        int act;
        act = 0;
        @(negedge clk);
        ctrl_wr = 1'b1; ctrl_op = op; cw_width = w;
        @(negedge clk);
        ctrl_wr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (enc_start || dec_start || busy || op_done || noise_en) act++;
            @(negedge clk);
        end
        chk({name, " activity"}, act, 0);
        chk({name, " status"}, status, 32'h0000_0008);
    endtask

    initial begin
        int act;
        n_checks = 0; n_errors = 0;
        ctrl_wr = 1'b0; ctrl_op = 2'b00; cw_width = 2'b00;
        enc_done = 1'b0; dec_done = 1'b0;

        //             op     w      enc    dec    ovr enc noi dec done busy status
        vecs[0] = '{2'b00, 2'b01, 5,     NEVER, 0,  1,  0,  0,  7,   6,   32'h0000_0042};
        vecs[1] = '{2'b10, 2'b10, 3,     4,     0,  1,  5,  6,  11,  10,  32'h0000_00A2};
        vecs[2] = '{2'b01, 2'b00, 0,     0,     0,  0,  0,  1,  2,   1,   32'h0000_0012};
        vecs[3] = '{2'b01, 2'b01, NEVER, NEVER, 0,  0,  0,  1,  256, 255, 32'h0000_0056};
        vecs[4] = '{2'b00, 2'b00, 0,     NEVER, 0,  1,  0,  0,  2,   1,   32'h0000_0002};
        vecs[5] = '{2'b00, 2'b10, 254,   NEVER, 0,  1,  0,  0,  256, 255, 32'h0000_0082};
        vecs[6] = '{2'b10, 2'b00, NEVER, NEVER, 0,  1,  0,  0,  256, 255, 32'h0000_0026};
        vecs[7] = '{2'b00, 2'b01, 5,     NEVER, 3,  1,  0,  0,  7,   6,   32'h0000_0142};
        vecs[8] = '{2'b01, 2'b00, NEVER, 0,     2,  0,  0,  1,  2,   1,   32'h0000_0112};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset outputs",
            {25'h0, enc_start, dec_start, dec_src_sel, noise_en, busy, op_done, 1'b0}, 32'h0);
        chk("reset status", status, 32'h0);
        chk("reset width_lat", {30'h0, width_lat}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_illegal("illegal op", 2'b11, 2'b00);
        run_illegal("illegal width", 2'b00, 2'b11);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset while in DEC_RUN: outputs drop without a clock edge.
        @(negedge clk);
        ctrl_wr = 1'b1; ctrl_op = 2'b01; cw_width = 2'b01;
        @(negedge clk);
        ctrl_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset busy", {31'h0, busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async reset outputs",
            {25'h0, enc_start, dec_start, dec_src_sel, noise_en, busy, op_done, 1'b0}, 32'h0);
        chk("async reset status", status, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        act = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (op_done || busy || enc_start || dec_start) act++;
        end
        chk("post-reset activity", act, 0);
        chk("post-reset status", status, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
